// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the multi-cycle data-memory responder.
//   state_e  : responder FSM states (IDLE / WAIT / RESP)
//   LANE_W   : byte-lane width in bits
//   req_t    : request captured on the accept edge
//   merge_be : merges store data into an old word under byte enables
package mem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 32 / LANE_W;

    typedef struct packed {
        logic                 write;
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic [NUM_LANES-1:0] be;
    } req_t;

    function automatic logic [31:0] merge_be(input logic [31:0]          old_w,
                                             input logic [31:0]          wdata,
                                             input logic [NUM_LANES-1:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < NUM_LANES; i++)
            if (be[i]) r[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: valid/ready request + response channels of the load/store port.
//   master : initiator (core / bench) side
//   slave  : responder side
//   req_*  : valid, ready, write, addr, wdata, be
//   resp_* : valid, ready, rdata, err
interface mem_responder_if;
    import mem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [NUM_LANES-1:0] req_be;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH_WORDS x 32 storage, synchronous byte-masked write, registered read.
//   clk   : clock
//   we/be : write strobe and per-byte lane enables
//   addr  : word index shared by read and write
//   wdata : store data
//   re    : read strobe; rdata holds its value between reads
//   rdata : registered read data (old contents on a same-edge write)
// Contents and rdata are deliberately not reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [NUM_LANES-1:0] be,
    input  logic [AW-1:0]        addr,
    input  logic [31:0]          wdata,
    input  logic                 re,
    output logic [31:0]          rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= merge_be(mem[addr], wdata, be);
        if (re) rdata     <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle target of the CPU load/store port.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_responder_if.slave (request and response channels)
// Parameters: DEPTH_WORDS (power of two, >=2), WAIT_CYCLES (0..255).
// Optional macro MEM_ALIGN_CHECK_EN: misaligned addresses (addr[1:0]!=0) are
// rejected with resp_err; otherwise the low address bits are ignored.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    req_t        req_q;
    logic        err_q;
    logic        rd_en_q;      // response carries array read data (ok load)
    logic [31:0] mem_rdata;
    logic        access, addr_ok, in_range;
    logic [31:0] word_num;

    assign access   = (state_q == WAIT) && (cnt_q == 8'd0);
    assign word_num = {2'b00, req_q.addr[31:2]};
    assign in_range = word_num < 32'(DEPTH_WORDS);

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_ok = in_range && (req_q.addr[1:0] == 2'b00);
`else
    assign addr_ok = in_range;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            rd_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.req_valid)
                cnt_q <= 8'(WAIT_CYCLES);
            else if (state_q == WAIT && cnt_q != 8'd0)
                cnt_q <= cnt_q - 8'd1;
            if (access) begin
                err_q   <= !addr_ok;
                rd_en_q <= addr_ok && !req_q.write;
            end
        end
    end

    // Request payload needs no reset; it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.req_valid)
            req_q <= '{write: bus.req_write, addr: bus.req_addr,
                       wdata: bus.req_wdata, be: bus.req_be};
    end

    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = WAIT;
            end
            WAIT: if (cnt_q == 8'd0) state_d = RESP;
            RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the write so a store whose access edge meets reset is dropped.
    mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .we    (access && addr_ok && req_q.write && rst_n),
        .be    (req_q.be),
        .addr  (req_q.addr[AW+1:2]),
        .wdata (req_q.wdata),
        .re    (access && addr_ok && !req_q.write),
        .rdata (mem_rdata)
    );

    assign bus.resp_rdata = rd_en_q ? mem_rdata : 32'd0;
    assign bus.resp_err   = err_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle data-memory responder: the target side of the CPU's load/store port, replacing the single-cycle combinational RAM as seen from the core. Accepts one request at a time over a valid/ready request channel. Performs the word access after a configurable number of wait states and returns the result over a valid/ready response channel. Used by the multi-cycle and pipelined core variants and as a slow-memory model in benches.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, ≥2.
- WAIT_CYCLES, 2: wait states between request acceptance and the access; 0..255.

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; lane 0 = bits 7:0.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator takes the response.
- resp_rdata  out  32  load data; 0 on stores and on errors.
- resp_err  out  1  access rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch write/addr/wdata/be, load cnt←WAIT_CYCLES, go to WAIT.
- WAIT:
  - req_ready=0.
  - cnt≠0: decrement cnt.
  - cnt==0: perform the access at this edge, latch resp_rdata/resp_err, go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until taken.
  - resp_ready=1 → IDLE.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Out of range (addr[31:2] ≥ DEPTH_WORDS): resp_err=1, rdata=0, no write.
- Store: write only the byte lanes with be set. be=0000 is a legal no-op with a normal response.
- Load: ignores be and returns the full word.
- Request inputs are sampled only on the accept edge. Changes afterwards have no effect.
- Storage contents are not reset; reads before any write return X in simulation.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cnt=0.
- Accept edge = rising edge with state IDLE and req_valid=1.
- resp_valid rises WAIT_CYCLES+2 cycles after the accept cycle. With WAIT_CYCLES=0, the response appears 2 cycles later.
- With resp_ready held high, resp_valid lasts 1 cycle, and req_ready returns the next cycle. Back-to-back period = WAIT_CYCLES+3 cycles.
- resp_ready low: stay in RESP indefinitely with outputs unchanged; no new request is accepted.
- No combinational path from req_* or resp_ready to any output; all outputs are registered or decoded from state.
- Reset asserted in WAIT or RESP:
  - Return to IDLE next edge; any pending store is dropped and no response is issued.
  - A store whose access edge coincides with reset is not performed.

## Configuration
- MEM_ALIGN_CHECK_EN defined: any request with addr[1:0]≠00 gets resp_err=1, rdata=0, no write. This is checked at the access edge, and the out-of-range check also applies.
- Undefined: addr[1:0] is ignored and the access goes to the containing word.

## Structure
- Package mem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - the byte-lane width constant (8);
  - a function that merges wdata into an old word under be.
- One sub-module, mem_array: a DEPTH_WORDS×32 synchronous-write, registered-read array with per-byte write enables. The FSM and wait counter stay in mem_responder.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Store then load, WAIT_CYCLES=2:
  - Store addr 0x10, data 0xDEADBEEF, be 1111: resp_valid rises 4 cycles after accept with resp_err=0.
  - Load 0x10: returns 0xDEADBEEF.
- Byte enables: word 0x10 holds 0xDEADBEEF; store 0x11223344 with be 0101 → load returns 0xDE22BE44.
- Out of range, DEPTH_WORDS=256: store to 0x400 → resp_err=1. Load 0x0 shows its contents are unchanged.
- Backpressure:
  - Hold resp_ready=0 for 5 cycles in RESP: resp_valid, rdata and err stay stable, and req_ready stays 0.
  - Release: the response completes in 1 cycle and req_ready=1 the next cycle.
- Reset mid-WAIT: assert rst_n=0 during WAIT of a store of 0xCAFEF00D to 0x20 → no response, state IDLE. A later load of 0x20 returns the old value.
- With MEM_ALIGN_CHECK_EN: load 0x12 → resp_err=1, rdata=0.
- Without MEM_ALIGN_CHECK_EN: load 0x12 returns the word at 0x10.
